// File: rtl/wb_merge_queue.sv
// In-order write-back queue that merges load and ALU results onto reg_file's single write port.
// Define WB_FWD_EN to build the forwarding lookup (fwd_hit/fwd_data); otherwise those outputs are tied low.
module wb_merge_queue #(
  parameter int pw    = 2,
  parameter int dw    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [pw-1:0] alu_addr,
  input  logic [dw-1:0] alu_data,
  input  logic          mem_valid,
  input  logic [pw-1:0] mem_addr,
  input  logic [dw-1:0] mem_data,
  output logic          stall,
  output logic          overflow,
  output logic          rf_wr_en,
  output logic [pw-1:0] rf_wr_addr,
  output logic [dw-1:0] rf_dat_in,
  input  logic [pw-1:0] fwd_addr,
  output logic          fwd_hit,
  output logic [dw-1:0] fwd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [pw-1:0] r_addr [DEPTH];
  logic [dw-1:0] r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic [CW-1:0] w_space;
  logic          w_pop;
  logic          w_mem_acc;
  logic          w_alu_acc;
  logic          w_drop;
  logic [CW-1:0] w_nacc;
  logic [AW-1:0] w_alu_slot;

  // Admission: space is judged on the current count, before this edge's pop; mem wins a single free slot.
  always_comb begin
    w_space    = DEPTH_C - r_count;
    w_pop      = (r_count != '0);
    w_mem_acc  = 1'b0;
    w_alu_acc  = 1'b0;
    if (mem_valid && alu_valid) begin
      w_mem_acc = (w_space >= CW'(1));
      w_alu_acc = (w_space >= CW'(2));
    end else begin
      w_mem_acc = mem_valid && (w_space >= CW'(1));
      w_alu_acc = alu_valid && (w_space >= CW'(1));
    end
    w_drop     = (mem_valid && !w_mem_acc) || (alu_valid && !w_alu_acc);
    w_nacc     = CW'(w_mem_acc) + CW'(w_alu_acc);
    if (w_mem_acc) begin
      w_alu_slot = r_tail + AW'(1);
    end else begin
      w_alu_slot = r_tail;
    end
  end

  // Queue storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_mem_acc) begin
        r_addr[r_tail] <= mem_addr;
        r_data[r_tail] <= mem_data;
      end
      if (w_alu_acc) begin
        r_addr[w_alu_slot] <= alu_addr;
        r_data[w_alu_slot] <= alu_data;
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      r_tail  <= r_tail + AW'(w_nacc);
      r_count <= r_count + w_nacc - CW'(w_pop);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Drain port presents the head entry whenever the queue is non-empty.
  always_comb begin
    rf_wr_en = w_pop;
    if (w_pop) begin
      rf_wr_addr = r_addr[r_head];
      rf_dat_in  = r_data[r_head];
    end else begin
      rf_wr_addr = '0;
      rf_dat_in  = '0;
    end
  end

  assign stall    = (w_space < CW'(2));
  assign overflow = r_overflow;

`ifdef WB_FWD_EN
  logic [AW-1:0] w_idx;

  // Walk occupied slots oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    w_idx    = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + AW'(i);
      if ((CW'(i) < r_count) && (r_addr[w_idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_data[w_idx];
      end else begin
        fwd_hit  = fwd_hit;
        fwd_data = fwd_data;
      end
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^fwd_addr;
  assign fwd_hit      = 1'b0;
  assign fwd_data     = '0;
`endif

endmodule

// File: tb/tb_wb_merge_queue.sv
// Scoreboard bench for wb_merge_queue: expected writes queued at stimulus time, popped as the DUT drains.
module tb_wb_merge_queue;

  localparam int PW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, mem_valid;
  logic [PW-1:0] alu_addr, mem_addr, fwd_addr;
  logic [DW-1:0] alu_data, mem_data;
  logic          stall, overflow, rf_wr_en, fwd_hit;
  logic [PW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_dat_in, fwd_data;

  always #5 clk = ~clk;

  wb_merge_queue #(.pw(PW), .dw(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .stall(stall), .overflow(overflow),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_dat_in(rf_dat_in),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  typedef struct packed {
    logic [PW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic ov_exp   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic          hit;
    logic [DW-1:0] fd;
    hit = 1'b0;
    fd  = '0;
`ifdef WB_FWD_EN
    foreach (sb[i]) begin
      if (sb[i].a == fwd_addr) begin
        hit = 1'b1;
        fd  = sb[i].d;
      end
    end
`endif
    check_eq({tag, ".wr_en"}, 32'(rf_wr_en), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check_eq({tag, ".wr_addr"}, 32'(rf_wr_addr), 32'(sb[0].a));
      check_eq({tag, ".dat_in"}, 32'(rf_dat_in), 32'(sb[0].d));
    end
    check_eq({tag, ".stall"}, 32'(stall), 32'((DEPTH - sb.size()) < 2));
    check_eq({tag, ".overflow"}, 32'(overflow), 32'(ov_exp));
    check_eq({tag, ".fwd_hit"}, 32'(fwd_hit), 32'(hit));
    check_eq({tag, ".fwd_data"}, 32'(fwd_data), 32'(fd));
  endtask

  task automatic step(input logic mv, input logic [PW-1:0] ma, input logic [DW-1:0] md,
                      input logic av, input logic [PW-1:0] aa, input logic [DW-1:0] ad,
                      input logic [PW-1:0] fa, input string tag);
    int   space;
    logic macc, aacc;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    fwd_addr  = fa;
    space = DEPTH - sb.size();
    macc  = mv && (space >= 1);
    aacc  = av && (space >= (macc ? 2 : 1));
    @(posedge clk);
    if (sb.size() != 0) void'(sb.pop_front());
    if (macc) sb.push_back(ent_t'{a: ma, d: md});
    if (aacc) sb.push_back(ent_t'{a: aa, d: ad});
    if ((mv && !macc) || (av && !aacc)) ov_exp = 1'b1;
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input logic [PW-1:0] fa, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, fa, tag);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    fwd_addr  = '0;
    #1 reset = 1'b1;
    @(negedge clk);
    check_outputs("reset");
    reset = 1'b0;
    idle(3, 2'd0, "idle");

    // Single ALU result: visible on the write port for exactly one cycle.
    step(1'b0, '0, '0, 1'b1, 2'd1, 8'h3C, 2'd1, "alu1");
    idle(2, 2'd1, "alu1_after");

    // Same destination from both sources: load written first, ALU value wins.
    step(1'b1, 2'd2, 8'hA5, 1'b1, 2'd2, 8'h11, 2'd2, "dual_same");
    idle(3, 2'd2, "dual_same_drain");

    // Back-to-back dual valids until the third cycle drops its ALU entry.
    step(1'b1, 2'd0, 8'h01, 1'b1, 2'd1, 8'h02, 2'd1, "burst1");
    step(1'b1, 2'd2, 8'h03, 1'b1, 2'd3, 8'h04, 2'd1, "burst2");
    check_eq("burst2.stall_set", 32'(stall), 32'd1);
    step(1'b1, 2'd0, 8'h05, 1'b1, 2'd1, 8'h06, 2'd0, "burst3");
    check_eq("burst3.overflow_set", 32'(overflow), 32'd1);
    idle(5, 2'd0, "burst_drain");

    // Reset while three entries are queued and draining.
    step(1'b1, 2'd1, 8'h10, 1'b1, 2'd2, 8'h20, 2'd1, "fill1");
    step(1'b1, 2'd3, 8'h30, 1'b1, 2'd0, 8'h40, 2'd1, "fill2");
    #2 reset = 1'b1;
    sb.delete();
    ov_exp = 1'b0;
    #1;
    check_eq("midrst.wr_en", 32'(rf_wr_en), 32'd0);
    check_eq("midrst.stall", 32'(stall), 32'd0);
    check_eq("midrst.overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, '0, '0, 1'b1, 2'd3, 8'h7F, 2'd3, "post_rst");
`ifndef WB_FWD_EN
    check_eq("nofwd.hit", 32'(fwd_hit), 32'd0);
    check_eq("nofwd.data", 32'(fwd_data), 32'd0);
`endif
    idle(2, 2'd3, "post_rst_drain");

    // Random traffic, including occasional ignored stalls.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), PW'($urandom), DW'($urandom),
           1'($urandom_range(0, 1)), PW'($urandom), DW'($urandom),
           PW'($urandom), "rand");
    end
    idle(6, 2'd0, "rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
